// File: rtl/sram_port0_arbiter.sv
// Round-robin two-requester sequencer for SRAM RW port 0: commands issue on the pins one cycle after the grant, and read data returns three cycles after the grant.
// A requester holds its command until gnt is seen; gnt depends only on req and the last winner, and at most one command issues per cycle.
module sram_port0_arbiter #(
  parameter int NUM_WMASKS = 4,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 9
) (
  input  logic                      clk0,
  input  logic                      rst0,
  input  logic [1:0]                req,
  input  logic [1:0]                we,
  input  logic [2*NUM_WMASKS-1:0]   wmask,
  input  logic [2*ADDR_WIDTH-1:0]   addr,
  input  logic [2*DATA_WIDTH-1:0]   wdata,
  output logic [1:0]                gnt,
  output logic [1:0]                rvalid,
  output logic [DATA_WIDTH-1:0]     rdata,
  output logic                      csb0,
  output logic                      web0,
  output logic [NUM_WMASKS-1:0]     wmask0,
  output logic [ADDR_WIDTH-1:0]     addr0,
  output logic [DATA_WIDTH-1:0]     din0,
  input  logic [DATA_WIDTH-1:0]     dout0
);

  logic                  last_q, last_d;
  logic                  csb0_q, csb0_d;
  logic                  web0_q, web0_d;
  logic [NUM_WMASKS-1:0] wmask0_q, wmask0_d;
  logic [ADDR_WIDTH-1:0] addr0_q, addr0_d;
  logic [DATA_WIDTH-1:0] din0_q, din0_d;
  logic [1:0]            rd_vld_q, rd_vld_d;
  logic [1:0]            rd_id_q, rd_id_d;
  logic [1:0]            rvalid_q, rvalid_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

  logic                  xfer;
  logic                  sel;
  logic [NUM_WMASKS-1:0] wmask_sel;
  logic [ADDR_WIDTH-1:0] addr_sel;
  logic [DATA_WIDTH-1:0] wdata_sel;

  // On a tie, the requester that did not win last gets the port.
  always_comb begin
    gnt = 2'b00;
    if (!rst0) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = last_q ? 2'b01 : 2'b10;
        default: gnt = 2'b00;
      endcase
    end
  end

  assign xfer      = |gnt;
  assign sel       = gnt[1];
  assign wmask_sel = sel ? wmask[2*NUM_WMASKS-1:NUM_WMASKS] : wmask[NUM_WMASKS-1:0];
  assign addr_sel  = sel ? addr[2*ADDR_WIDTH-1:ADDR_WIDTH]  : addr[ADDR_WIDTH-1:0];
  assign wdata_sel = sel ? wdata[2*DATA_WIDTH-1:DATA_WIDTH] : wdata[DATA_WIDTH-1:0];

  always_comb begin
    last_d   = xfer ? sel : last_q;
    csb0_d   = ~xfer;
    web0_d   = xfer ? ~we[sel] : 1'b1;
    wmask0_d = xfer ? wmask_sel : wmask0_q;
    addr0_d  = xfer ? addr_sel  : addr0_q;
    din0_d   = xfer ? wdata_sel : din0_q;

    // Stage 0 covers the pin cycle, stage 1 the cycle the macro drives dout0.
    rd_vld_d = {rd_vld_q[0], xfer & ~we[sel]};
    rd_id_d  = {rd_id_q[0], sel};

    rvalid_d = 2'b00;
    rdata_d  = rdata_q;
    if (rd_vld_q[1]) begin
      rvalid_d[rd_id_q[1]] = 1'b1;
      rdata_d              = dout0;
    end
  end

  always_ff @(posedge clk0 or posedge rst0) begin
    if (rst0) begin
      last_q   <= 1'b1;
      csb0_q   <= 1'b1;
      web0_q   <= 1'b1;
      wmask0_q <= '0;
      addr0_q  <= '0;
      din0_q   <= '0;
      rd_vld_q <= 2'b00;
      rd_id_q  <= 2'b00;
      rvalid_q <= 2'b00;
      rdata_q  <= '0;
    end else begin
      last_q   <= last_d;
      csb0_q   <= csb0_d;
      web0_q   <= web0_d;
      wmask0_q <= wmask0_d;
      addr0_q  <= addr0_d;
      din0_q   <= din0_d;
      rd_vld_q <= rd_vld_d;
      rd_id_q  <= rd_id_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
    end
  end

  assign csb0   = csb0_q;
  assign web0   = web0_q;
  assign wmask0 = wmask0_q;
  assign addr0  = addr0_q;
  assign din0   = din0_q;
  assign rvalid = rvalid_q;
  assign rdata  = rdata_q;

endmodule

// File: tb/tb_sram_port0_arbiter.sv
// Bench for sram_port0_arbiter: a behavioural SRAM macro, a transaction-level reference model and directed stimulus.
module tb_sram_port0_arbiter;

  logic        clk0 = 1'b0;
  logic        rst0 = 1'b1;
  logic [1:0]  req = '0, we = '0;
  logic [7:0]  wmask = '0;
  logic [17:0] addr = '0;
  logic [63:0] wdata = '0;
  logic [1:0]  gnt, rvalid;
  logic [31:0] rdata;
  logic        csb0, web0;
  logic [3:0]  wmask0;
  logic [8:0]  addr0;
  logic [31:0] din0;
  logic [31:0] dout0 = '0;

  int vectors = 0;
  int errors  = 0;
  int cyc     = 0;

  sram_port0_arbiter #(.NUM_WMASKS(4), .DATA_WIDTH(32), .ADDR_WIDTH(9)) dut (
    .clk0(clk0), .rst0(rst0), .req(req), .we(we), .wmask(wmask), .addr(addr), .wdata(wdata),
    .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .csb0(csb0), .web0(web0), .wmask0(wmask0),
    .addr0(addr0), .din0(din0), .dout0(dout0)
  );

  always #5 clk0 = ~clk0;
  always @(posedge clk0) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Macro: pins sampled on the rising edge, array access and dout0 on the next falling edge.
  logic [31:0] mac_mem [512];
  logic [31:0] ref_mem [512];
  logic        m_act = 1'b0, m_we = 1'b0;
  logic [3:0]  m_wm = '0;
  logic [8:0]  m_a = '0;
  logic [31:0] m_d = '0;

  initial begin
    for (int i = 0; i < 512; i++) begin
      mac_mem[i] = 32'hA500_0000 | i;
      ref_mem[i] = 32'hA500_0000 | i;
    end
  end

  always @(posedge clk0) begin
    m_act <= ~csb0;
    m_we  <= ~web0;
    m_wm  <= wmask0;
    m_a   <= addr0;
    m_d   <= din0;
  end

  always @(negedge clk0) begin
    if (m_act && m_we) begin
      for (int b = 0; b < 4; b++)
        if (m_wm[b]) mac_mem[m_a][b*8 +: 8] <= m_d[b*8 +: 8];
      dout0 <= 32'h0BAD_F00D;
    end else if (m_act) begin
      dout0 <= mac_mem[m_a];
    end else begin
      dout0 <= 32'h0BAD_F00D;
    end
  end

  // Reference model: each accepted read is scheduled for return three cycles after its grant.
  typedef struct {int due; logic id; logic [31:0] data;} rd_t;
  rd_t         rq[$];
  logic        m_last = 1'b1;
  logic        e_csb = 1'b1, e_web = 1'b1;
  logic [3:0]  e_wm = '0;
  logic [8:0]  e_addr = '0;
  logic [31:0] e_din = '0, e_rdata = '0;

  always @(negedge clk0) begin
    logic [1:0]  eg, erv;
    logic        id;
    logic [8:0]  a;
    logic [31:0] d;
    logic [3:0]  m;
    if (rst0) begin
      m_last = 1'b1; rq.delete();
      e_csb = 1'b1; e_web = 1'b1; e_wm = '0; e_addr = '0; e_din = '0; e_rdata = '0;
      chk("rst_gnt", gnt, 2'b00);
      chk("rst_rvalid", rvalid, 2'b00);
      chk("rst_rdata", rdata, 32'h0);
      chk("rst_csb0", csb0, 1'b1);
      chk("rst_web0", web0, 1'b1);
      chk("rst_addr0", addr0, 9'h0);
    end else begin
      if (req == 2'b11) eg = m_last ? 2'b01 : 2'b10;
      else              eg = req;
      erv = 2'b00;
      if (rq.size() > 0 && rq[0].due == cyc) begin
        erv[rq[0].id] = 1'b1;
        e_rdata = rq[0].data;
        void'(rq.pop_front());
      end
      chk("gnt", gnt, eg);
      chk("rvalid", rvalid, erv);
      chk("rdata", rdata, e_rdata);
      chk("csb0", csb0, e_csb);
      chk("web0", web0, e_web);
      chk("wmask0", wmask0, e_wm);
      chk("addr0", addr0, e_addr);
      chk("din0", din0, e_din);
      if (eg != 2'b00) begin
        id = eg[1];
        a  = addr[id*9 +: 9];
        d  = wdata[id*32 +: 32];
        m  = wmask[id*4 +: 4];
        m_last = id;
        e_csb = 1'b0; e_web = ~we[id]; e_wm = m; e_addr = a; e_din = d;
        if (we[id]) begin
          for (int b = 0; b < 4; b++)
            if (m[b]) ref_mem[a][b*8 +: 8] = d[b*8 +: 8];
        end else begin
          rq.push_back('{cyc + 3, id, ref_mem[a]});
        end
      end else begin
        e_csb = 1'b1; e_web = 1'b1;
      end
    end
  end

  task automatic drive(input logic [1:0] r, input logic [1:0] w, input logic [7:0] wm,
                       input logic [17:0] a, input logic [63:0] d);
    @(posedge clk0); #1;
    req = r; we = w; wmask = wm; addr = a; wdata = d;
  endtask

  task automatic drive1(input int id, input logic w, input logic [3:0] wm,
                        input logic [8:0] a, input logic [31:0] d);
    logic [7:0]  wmv;
    logic [17:0] av;
    logic [63:0] dv;
    wmv = '0; av = '0; dv = '0;
    wmv[id*4 +: 4] = wm; av[id*9 +: 9] = a; dv[id*32 +: 32] = d;
    drive(id == 0 ? 2'b01 : 2'b10, w ? (id == 0 ? 2'b01 : 2'b10) : 2'b00, wmv, av, dv);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive(2'b00, 2'b00, '0, '0, '0);
  endtask

  // Called right after a read has been driven; literal check of data and of the 3-cycle latency.
  task automatic expect_read(input int id, input logic [31:0] exp, input string name);
    bit found;
    found = 0;
    for (int k = 1; k <= 6 && !found; k++) begin
      @(posedge clk0); #1;
      req = 2'b00;
      #2;
      if (rvalid[id]) begin
        found = 1;
        chk({name, "_lat"}, k, 3);
        chk({name, "_data"}, rdata, exp);
      end
    end
    if (!found) chk({name, "_timeout"}, 0, 1);
  endtask

  initial begin
    logic [1:0]  mr, mw;
    logic [7:0]  mwm;
    logic [17:0] ma;
    logic [63:0] md;
    logic [1:0]  g;
    #23 rst0 = 1'b0;
    idle(4);

    // Contention: both read continuously; each requester moves to its next address once served.
    for (int t = 0; t < 6; t++) begin
      drive(2'b11, 2'b00, '0, {9'(32 + t/2), 9'(16 + (t+1)/2)}, '0);
      #2 chk("cont_gnt", gnt, (t % 2) ? 2'b10 : 2'b01);
    end
    idle(5);

    drive1(0, 1'b1, 4'hF, 9'd5, 32'hDEADBEEF);
    #2 chk("wr5_gnt", gnt, 2'b01);
    drive1(0, 1'b0, 4'h0, 9'd5, 32'h0);
    #2 chk("rd5_gnt", gnt, 2'b01);
    expect_read(0, 32'hDEADBEEF, "rd5");
    idle(2);

    drive1(0, 1'b1, 4'hF, 9'd7, 32'h11223344);
    drive1(0, 1'b1, 4'h5, 9'd7, 32'hAABBCCDD);
    drive1(0, 1'b0, 4'h0, 9'd7, 32'h0);
    expect_read(0, 32'h11BB33DD, "mask");
    idle(2);

    drive1(1, 1'b1, 4'hF, 9'd511, 32'h0000CAFE);
    drive1(0, 1'b0, 4'h0, 9'd511, 32'h0);
    expect_read(0, 32'h0000CAFE, "raw");
    idle(2);

    // Reset pulse in the cycle after a read grant.
    drive1(1, 1'b0, 4'h0, 9'd3, 32'h0);
    @(posedge clk0); #1;
    req = 2'b00;
    rst0 = 1'b1;
    #1;
    chk("async_csb0", csb0, 1'b1);
    chk("async_web0", web0, 1'b1);
    chk("async_addr0", addr0, 9'h0);
    chk("async_rdata", rdata, 32'h0);
    #6 rst0 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk0); #3;
      chk("rstrd_rvalid", rvalid, 2'b00);
      chk("rstrd_rdata", rdata, 32'h0);
    end

    // Mixed traffic with honest handshakes: a command changes only after its grant.
    mr = '0; mw = '0; mwm = '0; ma = '0; md = '0;
    for (int t = 0; t < 60; t++) begin
      for (int i = 0; i < 2; i++) begin
        if (t == 0 || !mr[i] || g[i]) begin
          mr[i] = ($urandom_range(0, 3) != 0);
          mw[i] = 1'($urandom_range(0, 1));
          mwm[i*4 +: 4] = 4'($urandom);
          ma[i*9 +: 9] = ($urandom_range(0, 5) == 0) ? 9'd511 : 9'($urandom_range(0, 7));
          md[i*32 +: 32] = $urandom;
        end
      end
      drive(mr, mw, mwm, ma, md);
      #2 g = gnt;
    end
    idle(6);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
